// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to add req_lock for multi-byte packets held by the current owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int START_TMO  = 64,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic                       transmit,
  output logic [7:0]                 tx_byte,
  input  logic                       is_transmitting,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       start_err
);

  localparam int          OW = $clog2(NUM_REQ);
  localparam int          CW = ($clog2(START_TMO + 1) > 8) ? $clog2(START_TMO + 1) : 8;
  localparam int unsigned N  = NUM_REQ;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_hold;
  logic          found;
  logic [OW-1:0] win;
  logic [OW-1:0] cand;

`ifdef UART_ARB_LOCK_EN
  assign lock_hold = req_lock[owner];
`else
  assign lock_hold = 1'b0;
`endif

  // Scan starts just after the last owner so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = owner;
    cand  = owner;
    if (lock_hold) begin
      found = req[owner];
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        cand = OW'((32'(owner) + k) % N);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= '0;
      transmit  <= 1'b0;
      tx_byte   <= '0;
      owner     <= OW'(NUM_REQ - 1);
      busy      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      ack       <= '0;
      transmit  <= 1'b0;
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !is_transmitting) begin
            state    <= LOAD;
            transmit <= 1'b1;
            ack      <= NUM_REQ'(1) << win;
            tx_byte  <= req_data[8*win +: 8];
            owner    <= win;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state <= WAIT_START;
          cnt   <= CW'(1);
        end
        // cnt starts at 1 so start_err lands exactly START_TMO cycles after transmit.
        WAIT_START: begin
          if (is_transmitting) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TMO - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            start_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!is_transmitting) begin
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= CW'(GAP_CYCLES);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
